// File: rtl/bcd_counter_nd.sv
// Multi-digit synchronous BCD counter: up/down counting, parallel load with digit
// clamping, and a wrap or saturate policy at the limits.
module bcd_counter_nd #(
    parameter int DIGITS   = 2,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] out,
    output logic                tc,
    output logic                load_err
);

    localparam int W   = 4 * DIGITS;
    localparam bit SAT = (SATURATE != 0);

    logic [W-1:0] count;
    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic [W-1:0] load_clamped;
    logic         all_nine;
    logic         all_zero;
    logic         load_bad;
    logic         inc_carry;
    logic         dec_borrow;

    // Carry and borrow ripple from digit 0 upward, so an all-9 increment naturally
    // produces all zeros and an all-0 decrement produces all nines.
    always_comb begin
        all_nine     = 1'b1;
        all_zero     = 1'b1;
        load_bad     = 1'b0;
        inc_carry    = 1'b1;
        dec_borrow   = 1'b1;
        inc_val      = count;
        dec_val      = count;
        load_clamped = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if (count[4*i +: 4] != 4'd9) all_nine = 1'b0;
            if (count[4*i +: 4] != 4'd0) all_zero = 1'b0;
            if (inc_carry) begin
                if (count[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    dec_borrow        = 1'b0;
                end
            end
            if (load_val[4*i +: 4] > 4'd9) begin
                load_clamped[4*i +: 4] = 4'd9;
                load_bad               = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            load_err <= 1'b0;
        end else if (load) begin
            count    <= load_clamped;
            load_err <= load_bad;
        end else begin
            load_err <= 1'b0;
            if (en) begin
                if (up) begin
                    if (!(SAT && all_nine)) count <= inc_val;
                end else begin
                    if (!(SAT && all_zero)) count <= dec_val;
                end
            end
        end
    end

    assign out = count;
    assign tc  = en & ~load & (up ? all_nine : all_zero);

endmodule

// File: tb/tb_bcd_counter_nd.sv
// Scoreboard bench: a wrapping and a saturating counter share one stimulus stream and
// are compared against an integer-arithmetic reference model.
module tb_bcd_counter_nd;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = 99;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] out0, out1;
    logic         tc0, tc1, err0, err1;

    typedef struct {
        logic [W-1:0] out0;
        logic [W-1:0] out1;
        logic         err;
    } out_exp_t;

    typedef struct {
        logic tc0;
        logic tc1;
    } tc_exp_t;

    out_exp_t outQ[$];
    tc_exp_t  tcQ[$];

    int checks = 0;
    int errors = 0;
    int v0 = 0;
    int v1 = 0;
    bit expErr = 1'b0;
    bit stimDone = 1'b0;

    always #5 clk = ~clk;

    bcd_counter_nd #(.DIGITS(DIGITS), .SATURATE(0)) dutWrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .out(out0), .tc(tc0), .load_err(err0)
    );

    bcd_counter_nd #(.DIGITS(DIGITS), .SATURATE(1)) dutSat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .out(out1), .tc(tc1), .load_err(err1)
    );

    function automatic logic [W-1:0] toBcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int stepModel(input int v, input bit sat, input bit dirUp);
        if (dirUp) return (v == MAXV) ? (sat ? MAXV : 0) : v + 1;
        return (v == 0) ? (sat ? 0 : MAXV) : v - 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit ld, input logic [W-1:0] lv,
                                 input bit e, input bit u);
        tc_exp_t  t;
        out_exp_t o;
        int       lval, scale, d;
        bit       bad;
        @(negedge clk);
        rst = r; load = ld; load_val = lv; en = e; up = u;
        t.tc0 = e && !ld && (u ? (v0 == MAXV) : (v0 == 0));
        t.tc1 = e && !ld && (u ? (v1 == MAXV) : (v1 == 0));
        tcQ.push_back(t);
        lval = 0; scale = 1; bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) begin
                d = 9;
                bad = 1'b1;
            end
            lval += d * scale;
            scale *= 10;
        end
        if (r) begin
            v0 = 0; v1 = 0; expErr = 1'b0;
        end else if (ld) begin
            v0 = lval; v1 = lval; expErr = bad;
        end else begin
            expErr = 1'b0;
            if (e) begin
                v0 = stepModel(v0, 1'b0, u);
                v1 = stepModel(v1, 1'b1, u);
            end
        end
        o.out0 = toBcd(v0);
        o.out1 = toBcd(v1);
        o.err  = expErr;
        outQ.push_back(o);
    endtask

    // Registered outputs settle just after the rising edge.
    initial begin : outMonitor
        out_exp_t o;
        forever begin
            @(posedge clk);
            #1;
            if (outQ.size() > 0) begin
                o = outQ.pop_front();
                checkOutput("out_wrap", 32'(out0), 32'(o.out0));
                checkOutput("out_sat", 32'(out1), 32'(o.out1));
                checkOutput("load_err_wrap", 32'(err0), 32'(o.err));
                checkOutput("load_err_sat", 32'(err1), 32'(o.err));
            end
        end
    end

    initial begin : tcMonitor
        tc_exp_t t;
        forever begin
            @(negedge clk);
            #1;
            if (tcQ.size() > 0) begin
                t = tcQ.pop_front();
                checkOutput("tc_wrap", 32'(tc0), 32'(t.tc0));
                checkOutput("tc_sat", 32'(tc1), 32'(t.tc1));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin : stimulus
        applyStimulus(1, 0, '0, 0, 0);
        applyStimulus(1, 0, '0, 0, 0);
        repeat (101) applyStimulus(0, 0, '0, 1, 1);

        applyStimulus(0, 1, 8'h19, 0, 0);
        repeat (21) applyStimulus(0, 0, '0, 1, 0);

        applyStimulus(0, 1, 8'h98, 0, 1);
        repeat (3) applyStimulus(0, 0, '0, 1, 1);
        applyStimulus(0, 1, 8'h01, 0, 0);
        repeat (3) applyStimulus(0, 0, '0, 1, 0);

        applyStimulus(0, 1, 8'h3C, 0, 0);
        applyStimulus(0, 1, 8'h42, 0, 0);
        applyStimulus(0, 0, '0, 0, 0);
        applyStimulus(0, 1, 8'hFA, 1, 1);
        applyStimulus(0, 0, '0, 0, 1);

        applyStimulus(0, 1, 8'h57, 0, 0);
        applyStimulus(1, 1, 8'h25, 1, 1);
        applyStimulus(0, 1, 8'h25, 1, 1);

        applyStimulus(0, 1, 8'h47, 0, 1);
        applyStimulus(0, 0, '0, 1, 1);
        applyStimulus(1, 0, '0, 1, 1);
        repeat (2) applyStimulus(0, 0, '0, 1, 1);
        applyStimulus(0, 1, 8'h50, 0, 1);
        applyStimulus(0, 0, '0, 1, 1);
        repeat (2) applyStimulus(0, 0, '0, 1, 0);

        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(31) == 0), ($urandom_range(7) == 0),
                          W'($urandom), ($urandom_range(3) != 0), 1'($urandom));
        end
        applyStimulus(0, 0, '0, 0, 0);
        stimDone = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        checkOutput("queues_drained", 32'(outQ.size() + tcQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
